// File: rtl/mac_row_feeder_pkg.sv
// Shared definitions for the MAC array west-edge feeder: inst bit layout,
// command op codes, FSM states and op-to-inst helpers.
package mac_row_feeder_pkg;

  localparam int INST_W    = 3;
  localparam int INST_OS   = 2;
  localparam int INST_EXEC = 1;
  localparam int INST_KF   = 0;

  localparam logic [INST_W-1:0] INST_BUBBLE = 3'b000;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_EXEC  = 2'b10,
    OP_FLUSH = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  // Kernel load only exists in WS, flush only in OS.
  function automatic logic op_legal(input op_e op, input logic os);
    logic ok;
    case (op)
      OP_LOAD:  ok = ~os;
      OP_EXEC:  ok = 1'b1;
      OP_FLUSH: ok = os;
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [INST_W-1:0] op_inst(input op_e op, input logic os);
    logic [INST_W-1:0] inst;
    inst            = INST_BUBBLE;
    inst[INST_OS]   = os;
    inst[INST_EXEC] = (op == OP_EXEC);
    inst[INST_KF]   = (op == OP_LOAD) || (op == OP_FLUSH);
    return inst;
  endfunction

endpackage

// File: rtl/mac_row_feeder_skew_pipe.sv
// Per-row delay line: depth stages of skew followed by the output register,
// so a word entering in cycle t is presented from edge t+1+depth.
module skew_pipe #(
  parameter int w     = 7,
  parameter int depth = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [w-1:0] i_d,
  output logic [w-1:0] o_q
);

  logic [w-1:0] r_q;

  generate
    if (depth == 0) begin : g_direct
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_q <= '0;
        end else begin
          r_q <= i_d;
        end
      end
    end else begin : g_shift
      logic [w-1:0] r_stage [depth];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < depth; i++) begin
            r_stage[i] <= '0;
          end
          r_q <= '0;
        end else begin
          r_stage[0] <= i_d;
          for (int i = 1; i < depth; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
          r_q <= r_stage[depth-1];
        end
      end
    end
  endgenerate

  assign o_q = r_q;

endmodule

// File: rtl/mac_row_feeder.sv
// West-edge feeder: sequences load/exec/flush passes into the MAC array rows,
// skewing row r by r cycles so the wavefront arrives aligned.
module mac_row_feeder
  import mac_row_feeder_pkg::*;
#(
  parameter int bw  = 4,
  parameter int row = 8,
  parameter int lw  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_start,
  input  logic [1:0]            cmd_op,
  input  logic                  cmd_os,
  input  logic [lw-1:0]         cmd_len,
  input  logic [row*bw-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [row*bw-1:0]     out_w,
  output logic [row*INST_W-1:0] inst_w,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int DW = $clog2(row);

  state_e        r_state, w_state_next;
  op_e           r_op, w_op_next;
  logic          r_os, w_os_next;
  logic [lw-1:0] r_remaining, w_remaining_next;
  logic [DW-1:0] r_drain, w_drain_next;
  logic          r_done, w_done_next;
  logic          r_err, w_err_next;

  logic              w_issue;
  logic              w_pass_data;
  logic [INST_W-1:0] w_slot_inst;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_NOP;
      r_os        <= 1'b0;
      r_remaining <= '0;
      r_drain     <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_op        <= w_op_next;
      r_os        <= w_os_next;
      r_remaining <= w_remaining_next;
      r_drain     <= w_drain_next;
      r_done      <= w_done_next;
      r_err       <= w_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_op_next        = r_op;
    w_os_next        = r_os;
    w_remaining_next = r_remaining;
    w_drain_next     = r_drain;
    w_done_next      = 1'b0;
    w_err_next       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_start) begin
          if (!op_legal(op_e'(cmd_op), cmd_os)) begin
            w_err_next = 1'b1;
          end else if (cmd_len == '0) begin
            w_done_next = 1'b1;
          end else begin
            w_state_next     = ST_ISSUE;
            w_op_next        = op_e'(cmd_op);
            w_os_next        = cmd_os;
            w_remaining_next = cmd_len;
          end
        end
      end
      ST_ISSUE: begin
        if (w_issue && (r_remaining != '0)) begin
          w_remaining_next = r_remaining - 1'b1;
          if (r_remaining == lw'(1)) begin
            w_state_next = ST_DRAIN;
            w_drain_next = DW'(row - 1);
          end
        end
      end
      ST_DRAIN: begin
        // Count 0 means the last slot is now on the deepest row; done follows it.
        if (r_drain == '0) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end else begin
          w_drain_next = r_drain - 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    w_issue     = 1'b0;
    w_pass_data = 1'b0;
    w_slot_inst = INST_BUBBLE;
    if ((r_state == ST_ISSUE) && (r_remaining != '0)) begin
      if (r_op == OP_FLUSH) begin
        w_issue     = 1'b1;
        w_slot_inst = op_inst(r_op, r_os);
      end else begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_issue     = 1'b1;
          w_pass_data = 1'b1;
          w_slot_inst = op_inst(r_op, r_os);
        end
      end
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign err  = r_err;

  for (genvar gi = 0; gi < row; gi++) begin : g_row
    logic [bw+INST_W-1:0] w_pipe_in;
    logic [bw+INST_W-1:0] w_pipe_out;

    assign w_pipe_in = {w_slot_inst, (w_pass_data ? in_data[gi*bw +: bw] : {bw{1'b0}})};

    skew_pipe #(
      .w    (bw + INST_W),
      .depth(gi)
    ) u_skew (
      .clk  (clk),
      .reset(reset),
      .i_d  (w_pipe_in),
      .o_q  (w_pipe_out)
    );

    assign out_w[gi*bw +: bw]          = w_pipe_out[bw-1:0];
    assign inst_w[gi*INST_W +: INST_W] = w_pipe_out[bw +: INST_W];
  end

endmodule

// File: tb/tb_mac_row_feeder.sv
// Scoreboard bench for mac_row_feeder: the driver predicts every row slot,
// done and err pulse; an independent monitor matches them against the outputs.
module tb_mac_row_feeder;

  localparam int ROW = 4;
  localparam int BW  = 4;
  localparam int LW  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_start = 1'b0;
  logic [1:0]        cmd_op = 2'b00;
  logic              cmd_os = 1'b0;
  logic [LW-1:0]     cmd_len = '0;
  logic [ROW*BW-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ROW*BW-1:0] out_w;
  logic [ROW*3-1:0]  inst_w;
  logic              busy;
  logic              done;
  logic              err;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]    inst;
    logic [BW-1:0] data;
    int            cyc;
  } slot_t;

  slot_t exp_q[ROW][$];
  int    done_q[$];
  int    err_q[$];

  mac_row_feeder #(.bw(BW), .row(ROW), .lw(LW)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_start(cmd_start),
    .cmd_op   (cmd_op),
    .cmd_os   (cmd_os),
    .cmd_len  (cmd_len),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_w    (out_w),
    .inst_w   (inst_w),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit model_legal(input logic [1:0] op, input logic os);
    return (op == 2'b01 && !os) || (op == 2'b10) || (op == 2'b11 && os);
  endfunction

  // Inst table: WS load 001, WS exec 010, OS exec 110, OS flush 101.
  function automatic logic [2:0] model_inst(input logic [1:0] op, input logic os);
    logic [2:0] v;
    case ({os, op})
      3'b001:  v = 3'b001;
      3'b010:  v = 3'b010;
      3'b110:  v = 3'b110;
      3'b111:  v = 3'b101;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // A slot issued in cycle t is visible on row r from cycle t+1+r.
  task automatic push_slots(input logic [2:0] inst, input logic [ROW*BW-1:0] d, input int t);
    for (int r = 0; r < ROW; r++) begin
      slot_t s;
      s.inst = inst;
      s.data = d[r*BW +: BW];
      s.cyc  = t + 1 + r;
      exp_q[r].push_back(s);
    end
  endtask

  task automatic monitor_step();
    slot_t s;
    for (int r = 0; r < ROW; r++) begin
      logic [2:0]    gi;
      logic [BW-1:0] gd;
      gi = inst_w[r*3 +: 3];
      gd = out_w[r*BW +: BW];
      if (gi != 3'b000 || gd != '0) begin
        n_cmp++;
        if (exp_q[r].size() == 0) begin
          n_fail++;
          $display("FAIL row%0d_unexpected_slot: got inst=%b data=%h, expected bubble (cycle %0d)", r, gi, gd, cyc);
        end else begin
          s = exp_q[r].pop_front();
          if (s.inst !== gi || s.data !== gd || s.cyc != cyc) begin
            n_fail++;
            $display("FAIL row%0d_slot: got inst=%b data=%h cyc=%0d, expected inst=%b data=%h cyc=%0d",
                     r, gi, gd, cyc, s.inst, s.data, s.cyc);
          end
        end
      end else if (exp_q[r].size() != 0 && exp_q[r][0].cyc <= cyc) begin
        n_cmp++;
        n_fail++;
        s = exp_q[r].pop_front();
        $display("FAIL row%0d_missing_slot: got bubble, expected inst=%b data=%h at cycle %0d (cycle %0d)",
                 r, s.inst, s.data, s.cyc, cyc);
      end
    end
    if (done) begin
      if (done_q.size() == 0) check("done_unexpected", 1, 0);
      else check("done_cycle", cyc, done_q.pop_front());
    end else if (done_q.size() != 0 && done_q[0] < cyc) begin
      check("done_missing", cyc, done_q.pop_front());
    end
    if (err) begin
      if (err_q.size() == 0) check("err_unexpected", 1, 0);
      else check("err_cycle", cyc, err_q.pop_front());
    end else if (err_q.size() != 0 && err_q[0] < cyc) begin
      check("err_missing", cyc, err_q.pop_front());
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) monitor_step();
    end
  end

  // vmode: 0 in_valid always high, 1 one-cycle gap after first vector, 2 random.
  task automatic run_pass(input logic [1:0] op, input logic os, input int len,
                          input int vmode, input bit fixed_data, input bit poke);
    int c0, acc, done_exp, guard;
    bit flush, gapped, v;
    logic [2:0] ei;
    @(negedge clk);
    cmd_start = 1'b1;
    cmd_op    = op;
    cmd_os    = os;
    cmd_len   = LW'(len);
    c0        = cyc;
    flush     = (op == 2'b11);
    ei        = model_inst(op, os);
    if (!model_legal(op, os)) begin
      err_q.push_back(c0 + 1);
      @(negedge clk);
      cmd_start = 1'b0;
      check("busy_after_illegal", busy, 0);
      return;
    end
    if (len == 0) begin
      done_q.push_back(c0 + 1);
      @(negedge clk);
      cmd_start = 1'b0;
      check("busy_after_len0", busy, 0);
      return;
    end
    done_exp = -1;
    if (flush) begin
      for (int k = 0; k < len; k++) push_slots(ei, '0, c0 + 1 + k);
      done_exp = c0 + len + ROW + 1;
      done_q.push_back(done_exp);
    end
    @(negedge clk);
    cmd_start = 1'b0;
    acc = 0;
    gapped = 1'b0;
    guard = 0;
    while (guard < 3000) begin
      guard++;
      if (cyc == c0 + 1) check("in_ready_first", in_ready, !flush);
      if (poke && cyc == c0 + 2) begin
        cmd_start = 1'b1;
        cmd_op    = 2'b00;
        cmd_len   = '0;
      end else if (poke && cyc == c0 + 3) begin
        cmd_start = 1'b0;
      end
      check("busy", busy, (done_exp < 0) || (cyc < done_exp));
      if (!flush && acc < len) begin
        case (vmode)
          0:       v = 1'b1;
          1:       begin v = !(acc == 1 && !gapped); if (!v) gapped = 1'b1; end
          default: v = ($urandom_range(0, 3) != 0);
        endcase
        in_valid = v;
        in_data  = fixed_data ? 16'(16'h1111 * (acc + 1)) : 16'($urandom);
        if (v && in_ready) begin
          push_slots(ei, in_data, cyc);
          acc++;
          if (acc == len) begin
            done_exp = cyc + ROW + 1;
            done_q.push_back(done_exp);
          end
        end
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 16'($urandom);
        check("in_ready_low", in_ready, 0);
      end
      if (done_exp >= 0 && cyc >= done_exp) break;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    cmd_start = 1'b0;
    if (guard >= 3000) check("pass_timeout", guard, 0);
  endtask

  task automatic reset_mid_pass();
    @(negedge clk);
    cmd_start = 1'b1;
    cmd_op    = 2'b10;
    cmd_os    = 1'b0;
    cmd_len   = 8'd10;
    @(negedge clk);
    cmd_start = 1'b0;
    repeat (3) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      check("in_ready_mid_issue", in_ready, 1);
      if (in_ready) push_slots(3'b010, in_data, cyc);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_out_w", out_w, 0);
    check("rst_inst_w", inst_w, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    for (int r = 0; r < ROW; r++) exp_q[r].delete();
    done_q.delete();
    err_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_out_w", out_w, 0);
    check("reset_inst_w", inst_w, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    run_pass(2'b01, 1'b0, 4, 0, 1'b1, 1'b0);   // WS load, fixed vectors
    run_pass(2'b10, 1'b0, 3, 1, 1'b0, 1'b0);   // WS exec with one bubble
    run_pass(2'b11, 1'b1, 4, 0, 1'b0, 1'b0);   // OS flush
    run_pass(2'b11, 1'b0, 5, 0, 1'b0, 1'b0);   // illegal: flush in WS
    run_pass(2'b01, 1'b1, 5, 0, 1'b0, 1'b0);   // illegal: load in OS
    run_pass(2'b00, 1'b0, 3, 0, 1'b0, 1'b0);   // illegal: no-op
    run_pass(2'b10, 1'b0, 0, 0, 1'b0, 1'b0);   // len 0
    run_pass(2'b10, 1'b1, 6, 2, 1'b0, 1'b1);   // cmd_start while busy
    reset_mid_pass();
    run_pass(2'b10, 1'b0, 5, 2, 1'b0, 1'b0);
    run_pass(2'b10, 1'b1, 255, 2, 1'b0, 1'b0); // OS exec, max length
    for (int i = 0; i < 10; i++) begin
      run_pass(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 12), 2, 1'b0, 1'b0);
    end

    repeat (10) @(negedge clk);
    for (int r = 0; r < ROW; r++) check($sformatf("row%0d_pending_slots", r), exp_q[r].size(), 0);
    check("pending_done", done_q.size(), 0);
    check("pending_err", err_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
